// File: rtl/arb_pkg.sv
// Shared types and constants for the 16-way round-robin arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package arb_pkg;

  localparam int NUM_REQ         = 16;
  localparam int IDX_W           = 4;
  localparam int CNT_W           = 8;
  localparam int TIMEOUT_CYC_DEF = 255;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // First set request at or after ptr, scanning upward with wrap 15->0.
  // The 4-bit candidate index wraps on its own, so no modulo is needed.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] req,
    input logic [IDX_W-1:0]   ptr
  );
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ptr + IDX_W'(i);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/decoder_4to16.sv
// 4-bit binary select to 16-bit one-hot, forced to zero when en is low.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module decoder_4to16 (
  input  logic [3:0]  sel,
  input  logic        en,
  output logic [15:0] dout
);

  // Set exactly the selected bit, or nothing when disabled.
  always_comb begin
    dout      = '0;
    if (en) begin
      dout[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter_16.sv
// 16-way round-robin arbiter with single owner hold until done; optional forced release via ARB_TIMEOUT_EN.
// Latency: grant one cycle after req in IDLE; one IDLE cycle after every release.
// Backpressure: an owner holds the resource regardless of req until done (or timeout when ARB_TIMEOUT_EN is defined).
module rr_arbiter_16
  import arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_idx,
`ifdef ARB_TIMEOUT_EN
  output logic        timeout,
`endif
  output logic        gnt_valid
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             expire;
  logic             timeout_q, timeout_d;

  // The counter is out of range for anything outside 1..255.
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("rr_arbiter_16: TIMEOUT_CYC must be in 1..255");
  end

  // Counter value after this BUSY cycle; hitting TIMEOUT_CYC means the owner used its allowance.
  assign cnt_inc = cnt_q + 8'd1;
  assign expire  = (cnt_inc == CNT_W'(TIMEOUT_CYC));
`else
  // Without the timeout feature the parameter has no effect on the hardware.
  if (TIMEOUT_CYC < 0) begin : g_timeout_unused
  end
`endif

  // Next-state, owner selection and pointer advance.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = BUSY;
          idx_d   = rr_pick(req, ptr_q);
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
`ifdef ARB_TIMEOUT_EN
        cnt_d = cnt_inc;
        if (done || expire) begin
          state_d   = IDLE;
          ptr_d     = idx_q + 4'd1;
          // A coincident done counts as a normal release.
          timeout_d = !done;
        end
`else
        if (done) begin
          state_d = IDLE;
          ptr_d   = idx_q + 4'd1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, owner and pointer registers; reset drops the grant asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Busy-cycle counter and the registered one-cycle timeout pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`endif

  assign gnt_valid = (state_q == BUSY);
  assign gnt_idx   = idx_q;

  decoder_4to16 u_dec (
    .sel  (idx_q),
    .en   (gnt_valid),
    .dout (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter_16.sv
module tb_rr_arbiter_16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic        timeout;

  int total = 0;
  int bad   = 0;

`ifdef ARB_TIMEOUT_EN
  localparam int TO = 4;
  localparam bit TE = 1'b1;
`else
  localparam int TO = 255;
  localparam bit TE = 1'b0;
`endif

  always #5 clk = ~clk;

  rr_arbiter_16 #(.TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
`ifdef ARB_TIMEOUT_EN
    .timeout   (timeout),
`endif
    .gnt_valid (gnt_valid)
  );

`ifndef ARB_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

  // Reference model: who owns the resource, where the next search starts,
  // how many busy cycles the owner has used, and whether a forced release just happened.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_cyc;
  bit m_to;

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_cyc   = 0;
    m_to    = 1'b0;
  endtask

  function automatic logic [15:0] exp_gnt();
    logic [15:0] one;
    one = 16'h0001;
    return m_busy ? (one << m_owner) : 16'h0000;
  endfunction

  // One rising edge: advance the model from the inputs seen at the edge, then settle.
  task automatic tick();
    @(posedge clk);
    m_to = 1'b0;
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      if (req != 16'h0000) begin
        for (int i = 0; i < 16; i++) begin
          if (req[(m_ptr + i) % 16]) begin
            m_owner = (m_ptr + i) % 16;
            break;
          end
        end
        m_busy = 1'b1;
        m_cyc  = 0;
      end
    end else if (done || (TE && (m_cyc + 1 == TO))) begin
      m_to   = TE && !done;
      m_busy = 1'b0;
      m_ptr  = (m_owner + 1) % 16;
    end else begin
      m_cyc++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = 16'hFFFF;
    done = 1'b0;
    model_reset();
    tick();
    tick();
    total++; if (gnt !== 16'h0000) begin bad++; $display("FAIL reset_gnt got=%h want=%h", gnt, 16'h0000); end
    total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", gnt_valid); end
    total++; if (gnt_idx !== 4'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", gnt_idx); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", timeout); end
    req = 16'h0000;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req = 16'h0001;
    tick();
    total++; if (gnt !== 16'h0001) begin bad++; $display("FAIL single_gnt got=%h want=0001", gnt); end
    total++; if (gnt_idx !== 4'd0 || gnt_valid !== 1'b1) begin bad++; $display("FAIL single_idx got=%0d/%b want=0/1", gnt_idx, gnt_valid); end
    tick();
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    total++; if (gnt !== 16'h0000 || gnt_valid !== 1'b0) begin bad++; $display("FAIL single_release got=%h/%b want=0000/0", gnt, gnt_valid); end
    // With ptr=1 the search must pass over requester 0.
    req = 16'h0003;
    tick();
    total++; if (gnt !== 16'h0002 || gnt_idx !== 4'd1) begin bad++; $display("FAIL single_ptr got=%h/%0d want=0002/1", gnt, gnt_idx); end
    done = 1'b1;
    req  = 16'h0000;
    tick();
    done = 1'b0;
    tick();
  endtask

  task automatic test_all_req();
    logic [15:0] one;
    logic [15:0] want;
    one = 16'h0001;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 16'hFFFF;
    for (int k = 0; k < 17; k++) begin
      tick();
      want = one << (k % 16);
      total++; if (gnt !== want || gnt_idx !== 4'(k % 16)) begin bad++; $display("FAIL all_req_order k=%0d got=%h/%0d want=%h/%0d", k, gnt, gnt_idx, want, k % 16); end
      total++; if ((gnt & (gnt - 16'd1)) !== 16'h0000) begin bad++; $display("FAIL all_req_onehot k=%0d got=%h want=one-hot", k, gnt); end
      done = 1'b1;
      tick();
      done = 1'b0;
      total++; if (gnt !== 16'h0000) begin bad++; $display("FAIL all_req_gap k=%0d got=%h want=0000", k, gnt); end
    end
    req = 16'h0000;
    tick();
  endtask

  task automatic test_wrap();
    req = 16'h4000;
    tick();
    total++; if (gnt_idx !== 4'd14) begin bad++; $display("FAIL wrap_pre got=%0d want=14", gnt_idx); end
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 16'h8001;
    tick();
    total++; if (gnt !== 16'h8000 || gnt_idx !== 4'd15) begin bad++; $display("FAIL wrap_15 got=%h/%0d want=8000/15", gnt, gnt_idx); end
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    total++; if (gnt !== 16'h0001 || gnt_idx !== 4'd0) begin bad++; $display("FAIL wrap_0 got=%h/%0d want=0001/0", gnt, gnt_idx); end
    done = 1'b1;
    req  = 16'h0000;
    tick();
    done = 1'b0;
    tick();
  endtask

  task automatic test_hold();
    req = 16'h0020;
    tick();
    total++; if (gnt !== 16'h0020) begin bad++; $display("FAIL hold_grant got=%h want=0020", gnt); end
    req = 16'h0000;
    tick();
    total++; if (gnt !== 16'h0020) begin bad++; $display("FAIL hold_drop1 got=%h want=0020", gnt); end
    req = 16'h0F00;
    tick();
    total++; if (gnt !== 16'h0020 || gnt_valid !== 1'b1) begin bad++; $display("FAIL hold_drop2 got=%h/%b want=0020/1", gnt, gnt_valid); end
    req  = 16'h0000;
    done = 1'b1;
    tick();
    done = 1'b0;
    total++; if (gnt !== 16'h0000) begin bad++; $display("FAIL hold_release got=%h want=0000", gnt); end
    // done while idle must not start or disturb anything.
    done = 1'b1;
    tick();
    done = 1'b0;
    total++; if (gnt !== 16'h0000 || gnt_idx !== 4'd5) begin bad++; $display("FAIL idle_done got=%h/%0d want=0000/5", gnt, gnt_idx); end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    req = 16'h0004;
    tick();
    total++; if (gnt !== 16'h0004) begin bad++; $display("FAIL to_grant got=%h want=0004", gnt); end
    req = 16'h0000;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (gnt !== 16'h0004 || timeout !== 1'b0) begin bad++; $display("FAIL to_hold c=%0d got=%h/%b want=0004/0", c, gnt, timeout); end
    end
    tick();
    total++; if (gnt !== 16'h0000 || timeout !== 1'b1) begin bad++; $display("FAIL to_release got=%h/%b want=0000/1", gnt, timeout); end
    req = 16'h000C;
    tick();
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_pulse_width got=%b want=0", timeout); end
    total++; if (gnt_idx !== 4'd3) begin bad++; $display("FAIL to_next got=%0d want=3", gnt_idx); end
    req = 16'h0000;
    tick();
    tick();
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    total++; if (gnt !== 16'h0000 || timeout !== 1'b0) begin bad++; $display("FAIL to_coincide got=%h/%b want=0000/0", gnt, timeout); end
    tick();
  endtask
`endif

  task automatic test_random();
    logic [15:0] want;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(3, 0))
        0:       req = 16'h0000;
        1:       req = 16'(1 << $urandom_range(15, 0));
        2:       req = 16'($urandom) & 16'($urandom);
        default: req = 16'($urandom);
      endcase
      done = ($urandom_range(2, 0) == 0);
      tick();
      want = exp_gnt();
      total++; if (gnt !== want || gnt_valid !== m_busy || gnt_idx !== 4'(m_owner) || timeout !== m_to) begin
        bad++;
        $display("FAIL random n=%0d got gnt=%h v=%b idx=%0d to=%b want gnt=%h v=%b idx=%0d to=%b",
                 n, gnt, gnt_valid, gnt_idx, timeout, want, m_busy, m_owner, m_to);
      end
      total++; if ((gnt & (gnt - 16'd1)) !== 16'h0000) begin bad++; $display("FAIL random_onehot n=%0d got=%h want=one-hot", n, gnt); end
    end
    req  = 16'h0000;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
  endtask

  task automatic test_reset_busy();
    req = 16'h0100;
    tick();
    total++; if (gnt !== 16'h0100) begin bad++; $display("FAIL rstb_grant got=%h want=0100", gnt); end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    total++; if (gnt !== 16'h0000 || gnt_valid !== 1'b0) begin bad++; $display("FAIL rstb_async got=%h/%b want=0000/0", gnt, gnt_valid); end
    tick();
    rst = 1'b0;
    // Requester 15 also asks: starting from ptr=0 owner 8 must still win.
    req = 16'h8100;
    tick();
    total++; if (gnt !== 16'h0100 || gnt_idx !== 4'd8) begin bad++; $display("FAIL rstb_resume got=%h/%0d want=0100/8", gnt, gnt_idx); end
    done = 1'b1;
    req  = 16'h0000;
    tick();
    done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst  = 1'b1;
    req  = 16'h0000;
    done = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_all_req();
    test_wrap();
    test_hold();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
